load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit between the single-cycle datapath and the data-memory bus. It takes the datapath's memory request (`aluout` as address, `writedata` as store data) and runs a valid/ready transaction on the word-wide memory bus, handling byte, halfword and word accesses. It returns aligned, extended load data to the datapath's `readdata` input and holds `stall` high until the access completes. Misaligned accesses and bus timeouts are reported as errors and never reach the bus or hang the core.

## Interface
- `TIMEOUT`, 255: BUSY cycles without `bus_ready` before the access is aborted; legal range 1..65535.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `req`  in  1  datapath requests a memory access; held until `done`
- `we`  in  1  1 = store, 0 = load
- `size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- `ld_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend
- `addr`  in  32  byte address (`aluout`)
- `wdata`  in  32  store data (`writedata`)
- `rdata`  out  32  extended load data (`readdata`)
- `done`  out  1  one-cycle pulse: access finished (ok or error)
- `stall`  out  1  freeze PC and register write
- `misalign`  out  1  one-cycle pulse with `done`: misaligned or illegal access
- `timeout`  out  1  one-cycle pulse with `done`: bus did not respond
- `bus_valid`  out  1  bus request
- `bus_we`  out  1  bus write
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`
- `bus_wdata`  out  32  lane-replicated store data
- `bus_be`  out  4  byte enables, bit i = byte lane i (little-endian)
- `bus_ready`  in  1  bus accepts/completes the request this cycle
- `bus_rdata`  in  32  read word; valid when `bus_ready` is high during a read

## Operation
- FSM states: IDLE, BUSY, DONE, ERR.
- **IDLE:** on `req`=1, register `we`, `size`, `ld_unsigned`, `addr` and `wdata`.
  - Misaligned or illegal access → ERR. This means `size`=11, halfword with `addr[0]`=1, or word with `addr[1:0]`≠00.
  - Any other access → BUSY.
- **BUSY:** `bus_valid`=1. All `bus_*` outputs come from registers and stay stable until `bus_ready` is sampled high.
  - On `bus_ready`=1 → DONE. For a load, capture the extracted `bus_rdata` into `rdata` on that edge.
  - The timeout counter starts at 0 on entry to BUSY and increments each BUSY cycle without `bus_ready`.
  - When the count reaches `TIMEOUT` with `bus_ready` still low → ERR with the timeout flag set.
- **DONE:** `done`=1 for one cycle, then → IDLE.
- **ERR:** `done`=1, plus `misalign`=1 or `timeout`=1 per cause, for one cycle. Set `rdata`=0, then → IDLE.
- **Byte enables:**
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<addr[1:0]`
  - word: `4'b1111`
- **Store data:**
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- **Load extract:** shift `bus_rdata` right by `8*addr[1:0]`, take the low 8/16/32 bits, then sign- or zero-extend per `ld_unsigned`.
- `stall` = `req & ~done`, combinational.
- `rdata` holds its value until the next load completes or an error occurs. Stores leave `rdata` unchanged.
- Changes to `req` or its inputs during BUSY are ignored. An access, once started, always completes.
- `req` seen in IDLE on the cycle right after DONE/ERR starts a new access.

## Timing
- Reset (`reset`=0, asynchronous): state IDLE, counter 0; `rdata`, `done`, `misalign`, `timeout`, `bus_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be` all 0.
  - Asserted mid-transaction, `bus_valid` drops immediately without waiting for a clock.
- Best-case access, with `req` sampled at edge 0:
  - `bus_valid` high in cycle 1;
  - `bus_ready` high in cycle 1, sampled at edge 1;
  - `done` high in cycle 2; the datapath writes back at edge 2. Latency is 2 cycles.
- Each wait cycle on `bus_ready` adds 1 cycle.
- Misaligned/illegal access: `done`+`misalign` high in cycle 1, no bus activity.
- Timeout: `bus_valid` high for exactly `TIMEOUT` cycles, then `done`+`timeout` on the next cycle.

## Test plan
- Word load, `addr`=0x10010004, `bus_rdata`=0xDEADBEEF, `bus_ready` high on the first cycle → `bus_addr`=0x10010004, `bus_be`=1111, `done` in cycle 2, `rdata`=0xDEADBEEF.
- Signed byte load, `addr`=...03, `bus_rdata`=0x80FFFFFF → `rdata`=0xFFFFFF80. The same access with `ld_unsigned`=1 → 0x00000080.
- Halfword store, `addr`=...02, `wdata`=0x1234ABCD, `bus_ready` delayed 3 cycles → `bus_be`=1100 and `bus_wdata`=0xABCDABCD held stable 4 cycles, `stall` high until `done`, `rdata` unchanged.
- Word load with `addr`=...02, and `size`=11 → `done`+`misalign` in cycle 1, `bus_valid` never asserted, `rdata`=0.
- `TIMEOUT`=4, `bus_ready` tied low → `bus_valid` high for 4 cycles, then `done`+`timeout`, `rdata`=0, back to IDLE.
- Assert `reset`=0 in the second BUSY cycle → `bus_valid` and all outputs 0 before the next edge. After release, a fresh load completes normally; back-to-back `req` after `done` starts a new access at the next edge.

Source files
------------

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: turns a datapath memory request into a valid/ready
// word-bus transaction with byte/halfword/word lanes, misalignment and timeout errors.
module load_store_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic        i_ld_unsigned,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_done,
   output logic        o_stall,
   output logic        o_misalign,
   output logic        o_timeout,
   output logic        o_bus_valid,
   output logic        o_bus_we,
   output logic [31:0] o_bus_addr,
   output logic [31:0] o_bus_wdata,
   output logic [3:0]  o_bus_be,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic [1:0]  r_size;
   logic [1:0]  r_off;
   logic        r_uns;
   logic [31:0] r_rdata;
   logic        r_done;
   logic        r_misalign;
   logic        r_timeout;
   logic        r_bus_valid;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [31:0] r_bus_wdata;
   logic [3:0]  r_bus_be;

   logic        w_misalign;
   logic [3:0]  w_be;
   logic [31:0] w_bwdata;
   logic [31:0] w_shift;
   logic [31:0] w_load;

   assign w_misalign = (i_size == 2'b11) ||
                       (i_size == 2'b01 && i_addr[0]) ||
                       (i_size == 2'b10 && i_addr[1:0] != 2'b00);

   always_comb begin
      w_be     = 4'b1111;
      w_bwdata = i_wdata;
      case (i_size)
         2'b00: begin
            w_be     = 4'b0001 << i_addr[1:0];
            w_bwdata = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = 4'b0011 << i_addr[1:0];
            w_bwdata = {2{i_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_bwdata = i_wdata;
         end
      endcase
   end

   // Extraction uses the registered offset/size, not the live request inputs.
   assign w_shift = i_bus_rdata >> {r_off, 3'b000};

   always_comb begin
      w_load = w_shift;
      case (r_size)
         2'b00:   w_load = r_uns ? {24'h000000, w_shift[7:0]}
                                 : {{24{w_shift[7]}}, w_shift[7:0]};
         2'b01:   w_load = r_uns ? {16'h0000, w_shift[15:0]}
                                 : {{16{w_shift[15]}}, w_shift[15:0]};
         default: w_load = w_shift;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_size      <= '0;
         r_off       <= '0;
         r_uns       <= 1'b0;
         r_rdata     <= '0;
         r_done      <= 1'b0;
         r_misalign  <= 1'b0;
         r_timeout   <= 1'b0;
         r_bus_valid <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_be    <= '0;
      end else begin
         r_done     <= 1'b0;
         r_misalign <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_req) begin
                  r_size <= i_size;
                  r_off  <= i_addr[1:0];
                  r_uns  <= i_ld_unsigned;
                  r_cnt  <= '0;
                  if (w_misalign) begin
                     r_state    <= S_ERR;
                     r_done     <= 1'b1;
                     r_misalign <= 1'b1;
                     r_rdata    <= '0;
                  end else begin
                     r_state     <= S_BUSY;
                     r_bus_valid <= 1'b1;
                     r_bus_we    <= i_we;
                     r_bus_addr  <= {i_addr[31:2], 2'b00};
                     r_bus_wdata <= w_bwdata;
                     r_bus_be    <= w_be;
                  end
               end
            end
            S_BUSY: begin
               if (i_bus_ready) begin
                  r_state     <= S_DONE;
                  r_done      <= 1'b1;
                  r_bus_valid <= 1'b0;
                  if (!r_bus_we) begin
                     r_rdata <= w_load;
                  end
               end else if (r_cnt == CNT_LAST) begin
                  // This is the TIMEOUT-th BUSY cycle without a response.
                  r_state     <= S_ERR;
                  r_done      <= 1'b1;
                  r_timeout   <= 1'b1;
                  r_rdata     <= '0;
                  r_bus_valid <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            S_ERR: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_rdata     = r_rdata;
   assign o_done      = r_done;
   assign o_stall     = i_req & ~r_done;
   assign o_misalign  = r_misalign;
   assign o_timeout   = r_timeout;
   assign o_bus_valid = r_bus_valid;
   assign o_bus_we    = r_bus_we;
   assign o_bus_addr  = r_bus_addr;
   assign o_bus_wdata = r_bus_wdata;
   assign o_bus_be    = r_bus_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random accesses
// against a byte-lane reference model, and reset/back-to-back sequences.
module tb_load_store_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_req = 1'b0;
   logic        i_we = 1'b0;
   logic [1:0]  i_size = '0;
   logic        i_ld_unsigned = 1'b0;
   logic [31:0] i_addr = '0;
   logic [31:0] i_wdata = '0;
   logic        i_bus_ready = 1'b0;
   logic [31:0] i_bus_rdata = '0;
   logic [31:0] o_rdata;
   logic        o_done, o_stall, o_misalign, o_timeout;
   logic        o_bus_valid, o_bus_we;
   logic [31:0] o_bus_addr, o_bus_wdata;
   logic [3:0]  o_bus_be;

   int checks = 0;
   int errors = 0;
   logic [31:0] model_rdata = '0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT(TO)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we), .i_size(i_size),
      .i_ld_unsigned(i_ld_unsigned), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rdata(o_rdata), .o_done(o_done), .o_stall(o_stall), .o_misalign(o_misalign),
      .o_timeout(o_timeout), .o_bus_valid(o_bus_valid), .o_bus_we(o_bus_we),
      .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_be(o_bus_be),
      .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata)
   );

   typedef struct {
      int          lat;
      int          vcnt;
      bit          mis;
      bit          to;
      logic [3:0]  be;
      logic [31:0] bwd;
      logic [31:0] baddr;
      bit          bwe;
      logic [31:0] rdata;
      bit          stable;
      bit          stall_ok;
      bit          pulse_ok;
   } obs_t;

   typedef struct {
      bit          we;
      logic [1:0]  sz;
      bit          uns;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] brd;
      int          delay;
      logic [31:0] e_rdata;
      logic [3:0]  e_be;
      logic [31:0] e_bwd;
      bit          e_mis;
      bit          e_to;
      int          e_lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model (byte-lane arithmetic) ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
   endfunction

   function automatic bit m_mis(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd3) return 1'b1;
      return (a % nbytes(sz)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
      logic [3:0] be = '0;
      int off = int'(a % 4);
      for (int i = 0; i < 4; i++)
         be[i] = (i >= off) && (i < off + nbytes(sz));
      return be;
   endfunction

   function automatic logic [31:0] m_bwd(input logic [1:0] sz, input logic [31:0] wd);
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input bit uns,
                                          input logic [31:0] a, input logic [31:0] brd);
      logic [31:0] v = '0;
      int n = nbytes(sz);
      int off = int'(a % 4);
      for (int k = 0; k < n; k++)
         v[8*k +: 8] = brd[8*(off+k) +: 8];
      if (!uns && n < 4 && v[8*n-1])
         v = v | ~((32'd1 << (8*n)) - 32'd1);
      return v;
   endfunction

   // ---------------- bus-side driver / observer ----------------
   task automatic run_access(input bit we, input logic [1:0] sz, input bit uns,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] brd, input int delay,
                             input bit hold, input bit scramble, output obs_t o);
      o = '{lat: -1, vcnt: 0, mis: 0, to: 0, be: '0, bwd: '0, baddr: '0, bwe: 0,
            rdata: '0, stable: 1, stall_ok: 1, pulse_ok: 1};
      i_req = 1'b1; i_we = we; i_size = sz; i_ld_unsigned = uns;
      i_addr = a; i_wdata = wd; i_bus_ready = 1'b0;
      @(posedge clk);
      if (scramble) begin
         #1;
         i_addr = $urandom; i_wdata = $urandom; i_size = 2'($urandom_range(0, 3));
         i_we = 1'($urandom); i_ld_unsigned = 1'($urandom);
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (o_stall !== (o_done ? 1'b0 : 1'b1)) o.stall_ok = 0;
         if (!o_done && (o_misalign || o_timeout)) o.pulse_ok = 0;
         if (o_bus_valid) begin
            o.vcnt++;
            if (o.vcnt == 1) begin
               o.be = o_bus_be; o.bwd = o_bus_wdata; o.baddr = o_bus_addr; o.bwe = o_bus_we;
            end else if (o_bus_be !== o.be || o_bus_wdata !== o.bwd ||
                         o_bus_addr !== o.baddr || o_bus_we !== o.bwe) begin
               o.stable = 0;
            end
            i_bus_ready = (o.vcnt == delay + 1);
            i_bus_rdata = i_bus_ready ? brd : $urandom;
         end else begin
            i_bus_ready = 1'b0;
         end
         if (o_done) begin
            o.lat = c; o.mis = o_misalign; o.to = o_timeout; o.rdata = o_rdata;
            break;
         end
      end
      @(posedge clk);
      #1;
      i_bus_ready = 1'b0;
      if (!hold) i_req = 1'b0;
      @(negedge clk);
      if (o_done || o_misalign || o_timeout || o_bus_valid) o.pulse_ok = 0;
   endtask

   task automatic check_obs(input string tag, input obs_t o, input bit we,
                            input logic [31:0] a, input int e_lat, input bit e_mis,
                            input bit e_to, input logic [31:0] e_rdata,
                            input logic [3:0] e_be, input logic [31:0] e_bwd);
      int e_vcnt = e_mis ? 0 : e_to ? int'(TO) : e_lat - 1;
      chk({tag, " latency"}, o.lat, e_lat);
      chk({tag, " valid_cycles"}, o.vcnt, e_vcnt);
      chk({tag, " misalign"}, {31'd0, o.mis}, {31'd0, e_mis});
      chk({tag, " timeout"}, {31'd0, o.to}, {31'd0, e_to});
      chk({tag, " rdata"}, o.rdata, e_rdata);
      chk({tag, " stall"}, {31'd0, o.stall_ok}, 32'd1);
      chk({tag, " pulse"}, {31'd0, o.pulse_ok}, 32'd1);
      if (e_vcnt > 0) begin
         chk({tag, " bus_be"}, {28'd0, o.be}, {28'd0, e_be});
         chk({tag, " bus_addr"}, o.baddr, a & 32'hFFFF_FFFC);
         chk({tag, " bus_we"}, {31'd0, o.bwe}, {31'd0, we});
         chk({tag, " bus_stable"}, {31'd0, o.stable}, 32'd1);
         if (we) chk({tag, " bus_wdata"}, o.bwd, e_bwd);
      end
   endtask

   task automatic random_one(input int idx);
      bit we = 1'($urandom);
      logic [1:0] sz = 2'($urandom_range(0, 3));
      bit uns = 1'($urandom);
      logic [31:0] a = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] brd = $urandom;
      int delay = int'($urandom_range(0, 5));
      bit mis = m_mis(sz, a);
      bit to = !mis && (delay >= int'(TO));
      int lat = mis ? 1 : to ? int'(TO) + 1 : delay + 2;
      obs_t o;
      if (mis || to) model_rdata = '0;
      else if (!we) model_rdata = m_load(sz, uns, a, brd);
      run_access(we, sz, uns, a, wd, brd, delay, 1'b0, 1'b1, o);
      check_obs($sformatf("rnd%0d", idx), o, we, a, lat, mis, to, model_rdata,
                m_be(sz, a), m_bwd(sz, wd));
   endtask

   vec_t tv[12];
   obs_t ob;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got hang expected completion");
      $fatal(1);
   end

   initial begin
      tv[0]  = '{0, 2'd2, 0, 32'h1001_0004, 32'h0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 0, 2};
      tv[1]  = '{0, 2'd0, 0, 32'h1001_0003, 32'h0, 32'h80FF_FFFF, 0, 32'hFFFF_FF80, 4'h8, 32'h0, 0, 0, 2};
      tv[2]  = '{0, 2'd0, 1, 32'h1001_0003, 32'h0, 32'h80FF_FFFF, 0, 32'h0000_0080, 4'h8, 32'h0, 0, 0, 2};
      tv[3]  = '{1, 2'd1, 0, 32'h1001_0002, 32'h1234_ABCD, 32'h0, 3, 32'h0000_0080, 4'hC, 32'hABCD_ABCD, 0, 0, 5};
      tv[4]  = '{0, 2'd2, 0, 32'h1001_0002, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 1};
      tv[5]  = '{0, 2'd1, 0, 32'h1001_0002, 32'h0, 32'h8001_1234, 1, 32'hFFFF_8001, 4'hC, 32'h0, 0, 0, 3};
      tv[6]  = '{0, 2'd3, 0, 32'h1001_0000, 32'h0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, 0, 1};
      tv[7]  = '{0, 2'd2, 0, 32'h0000_0100, 32'h0, 32'h1234_5678, 9, 32'h0, 4'hF, 32'h0, 0, 1, 5};
      tv[8]  = '{1, 2'd0, 0, 32'h1001_0001, 32'h0000_00A5, 32'h0, 2, 32'h0, 4'h2, 32'hA5A5_A5A5, 0, 0, 4};
      tv[9]  = '{0, 2'd1, 1, 32'h2000_0000, 32'h0, 32'h1234_F00D, 0, 32'h0000_F00D, 4'h3, 32'h0, 0, 0, 2};
      tv[10] = '{1, 2'd2, 0, 32'h0000_0030, 32'hCAFE_F00D, 32'h0, 4, 32'h0, 4'hF, 32'hCAFE_F00D, 0, 1, 5};
      tv[11] = '{0, 2'd0, 0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 0, 32'h0000_007F, 4'h2, 32'h0, 0, 0, 2};

      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset rdata", o_rdata, 32'h0);
      chk("reset flags", {28'd0, o_done, o_misalign, o_timeout, o_bus_valid}, 32'h0);
      chk("reset bus", {o_bus_addr ^ o_bus_wdata, 3'd0, o_bus_we, o_bus_be}, 32'h0);
      i_reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_access(tv[i].we, tv[i].sz, tv[i].uns, tv[i].a, tv[i].wd, tv[i].brd,
                    tv[i].delay, 1'b0, 1'b0, ob);
         check_obs($sformatf("vec%0d", i), ob, tv[i].we, tv[i].a, tv[i].e_lat, tv[i].e_mis,
                   tv[i].e_to, tv[i].e_rdata, tv[i].e_be, tv[i].e_bwd);
      end
      model_rdata = 32'h0000_007F;

      for (int i = 0; i < 60; i++) random_one(i);

      run_access(1'b0, 2'd2, 1'b0, 32'h0000_0044, 32'h0, 32'h55AA_55AA, 0, 1'b0, 1'b0, ob);
      check_obs("preload", ob, 1'b0, 32'h44, 2, 0, 0, 32'h55AA_55AA, 4'hF, 32'h0);

      // Reset asserted asynchronously in the second BUSY cycle.
      i_req = 1'b1; i_we = 1'b0; i_size = 2'd2; i_addr = 32'h0000_0040; i_bus_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("midreset busy", {31'd0, o_bus_valid}, 32'd1);
      #1 i_reset = 1'b0;
      #1;
      chk("midreset valid", {31'd0, o_bus_valid}, 32'd0);
      chk("midreset rdata", o_rdata, 32'h0);
      chk("midreset flags", {28'd0, o_done, o_misalign, o_timeout, o_bus_we}, 32'h0);
      chk("midreset bus", {o_bus_addr | o_bus_wdata, 4'd0, o_bus_be}, 32'h0);
      i_req = 1'b0;
      @(negedge clk);
      i_reset = 1'b1;

      run_access(1'b0, 2'd1, 1'b0, 32'h0000_0082, 32'h0, 32'hF00D_1234, 1, 1'b1, 1'b0, ob);
      check_obs("after_reset", ob, 1'b0, 32'h82, 3, 0, 0, 32'hFFFF_F00D, 4'hC, 32'h0);
      run_access(1'b1, 2'd0, 0, 32'h0000_0083, 32'h0000_0011, 32'h0, 0, 1'b0, 1'b0, ob);
      check_obs("back2back", ob, 1'b1, 32'h83, 2, 0, 0, 32'hFFFF_F00D, 4'h8, 32'h1111_1111);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
